// File: rtl/ram_mutex_pkg.sv
// Shared definitions for the RAM mutex and its node-side clients.
package ram_mutex_pkg;

  localparam logic [15:0] START_BASE = 16'hFC00;
  localparam logic [15:0] STOP_WORD  = 16'hFCFF;
  localparam logic [3:0]  FUNC_TAG   = 4'hC;

  typedef enum logic [1:0] {
    OpRead     = 2'b00,
    OpWrite    = 2'b01,
    OpGarbage  = 2'b10,
    OpAddFrame = 2'b11
  } mutex_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StOp,
    StHold,
    StLocked,
    StStop
  } client_state_e;

  // One-hot byte the mutex shows in out_node[15:8] for the owning node.
  function automatic logic [7:0] grant_byte(input int unsigned node);
    return 8'h01 << node;
  endfunction

endpackage

// File: rtl/ram_mutex_client.sv
// Node-side initiator for the shared RAM mutex: arbitrate, issue one command word,
// capture the returned byte, then either keep the lock or release it with the stop word.
module ram_mutex_client
  import ram_mutex_pkg::*;
#(
  parameter int unsigned NODE_ID       = 0,
  parameter int unsigned GRANT_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_arg,
  input  logic [3:0]  cmd_prio,
  input  logic        cmd_last,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] op_word,
  input  logic [15:0] grant_word
);

  localparam int unsigned    CntW      = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [7:0]     GrantByte = grant_byte(NODE_ID);
  localparam logic [CntW-1:0] CntMax   = CntW'(GRANT_TIMEOUT);

  client_state_e   state_q, state_d;
  mutex_op_e       op_q, op_d;
  logic [7:0]      arg_q, arg_d;
  logic [3:0]      prio_q, prio_d;
  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  logic [15:0]     start_word;
  logic            grant_ok;
  logic [CntW-1:0] cnt_inc;

  assign start_word = START_BASE | {12'h000, prio_q};
  assign grant_ok   = (grant_word[15:8] == GrantByte);
  assign cnt_inc    = cnt_q + CntW'(1);

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != StIdle);

  // State, command latch, timeout counter and response registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      op_q        <= OpRead;
      arg_q       <= 8'h00;
      prio_q      <= 4'h1;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      arg_q       <= arg_d;
      prio_q      <= prio_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic and the word driven to the mutex.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    arg_d       = arg_q;
    prio_d      = prio_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = 8'h00;
    rsp_err_d   = 1'b0;
    op_word     = 16'h0000;
    cmd_ready   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = mutex_op_e'(cmd_op);
          arg_d   = cmd_arg;
          last_d  = cmd_last;
          prio_d  = (cmd_prio == 4'h0) ? 4'h1 : cmd_prio;
          cnt_d   = '0;
          state_d = StArb;
        end
      end
      StArb: begin
        op_word = start_word;
        // Grant is checked first so it wins over a timeout on the same edge.
        if (grant_ok) begin
          state_d = StOp;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntMax) begin
            // Abort via STOP: the grant may have just landed inside the mutex.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = StStop;
          end
        end
      end
      StOp: begin
        op_word = {2'b00, op_q, FUNC_TAG, arg_q};
        state_d = StHold;
      end
      StHold: begin
        op_word     = start_word;
        rsp_valid_d = 1'b1;
        if (!grant_ok) begin
          rsp_err_d = 1'b1;
          state_d   = StStop;
        end else begin
          rsp_data_d = (op_q == OpRead) ? grant_word[7:0] : 8'h00;
          state_d    = last_q ? StStop : StLocked;
        end
      end
      StLocked: begin
        op_word   = start_word;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = mutex_op_e'(cmd_op);
          arg_d   = cmd_arg;
          last_d  = cmd_last;
          state_d = StOp;
        end
      end
      StStop: begin
        op_word = STOP_WORD;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_ram_mutex_client.sv
// Two clients (node0, node1) sharing a small behavioural mutex; responses are
// checked against a per-node scoreboard of hand-computed data, error and cycle.
module tb_ram_mutex_client;
  import ram_mutex_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [1:0]  cmd_op    [2];
  logic [7:0]  cmd_arg   [2];
  logic [3:0]  cmd_prio  [2];
  logic        cmd_last  [2];
  logic        rsp_valid [2];
  logic [7:0]  rsp_data  [2];
  logic        rsp_err   [2];
  logic        busy      [2];
  logic [15:0] op_word   [2];
  logic [15:0] grant_word;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         cyc;
  } exp_t;
  exp_t exp_q0[$];
  exp_t exp_q1[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  ram_mutex_client #(.NODE_ID(0), .GRANT_TIMEOUT(64)) u_node0 (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
    .cmd_arg(cmd_arg[0]), .cmd_prio(cmd_prio[0]), .cmd_last(cmd_last[0]),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
    .busy(busy[0]), .op_word(op_word[0]), .grant_word(grant_word)
  );

  ram_mutex_client #(.NODE_ID(1), .GRANT_TIMEOUT(4)) u_node1 (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
    .cmd_arg(cmd_arg[1]), .cmd_prio(cmd_prio[1]), .cmd_last(cmd_last[1]),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
    .busy(busy[1]), .op_word(op_word[1]), .grant_word(grant_word)
  );

  // Behavioural mutex: start words registered one edge, arbitration the next;
  // the owner's command word executes on the edge it is seen.
  logic       req_q  [2];
  logic [3:0] mprio_q [2];
  logic       own_v;
  logic       own_n;
  logic [7:0] mdata;
  logic [7:0] frame [16];
  logic [15:0] own_word;

  assign own_word   = op_word[own_n];
  assign grant_word = own_v ? {8'h01 << own_n, mdata} : {8'h00, mdata};

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int n = 0; n < 2; n++) begin
        req_q[n]   <= 1'b0;
        mprio_q[n] <= 4'h0;
      end
      own_v <= 1'b0;
      own_n <= 1'b0;
      mdata <= 8'h00;
      for (int i = 0; i < 16; i++) frame[i] <= 8'h00;
      frame[3] <= 8'h5A;
    end else begin
      for (int n = 0; n < 2; n++) begin
        req_q[n]   <= (op_word[n][15:4] == 12'hFC0);
        mprio_q[n] <= op_word[n][3:0];
      end
      if (own_v) begin
        if (own_word == 16'hFCFF) begin
          own_v <= 1'b0;
        end else if (own_word[15:14] == 2'b00 && own_word[11:8] == 4'hC) begin
          case (own_word[13:12])
            2'b00:   mdata <= frame[own_word[3:0]];
            2'b01: begin
              frame[0] <= own_word[7:0];
              mdata    <= 8'h00;
            end
            default: mdata <= 8'h00;
          endcase
        end
      end else if (req_q[0] || req_q[1]) begin
        own_v <= 1'b1;
        own_n <= req_q[1] && (!req_q[0] || mprio_q[1] > mprio_q[0]);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_check(input int n);
    exp_t e;
    bit found = 0;
    if (n == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); found = 1; end
    if (n == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); found = 1; end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL node%0d unexpected rsp_valid: data %h err %b at cycle %0d",
               n, rsp_data[n], rsp_err[n], cyc);
    end else begin
      check($sformatf("node%0d rsp_data", n), 16'(rsp_data[n]), 16'(e.data));
      check($sformatf("node%0d rsp_err", n), 16'(rsp_err[n]), 16'(e.err));
      check($sformatf("node%0d rsp cycle", n), 16'(cyc), 16'(e.cyc));
    end
  endtask

  // Monitor: compare every response pulse against the scoreboard.
  always @(negedge CLK) begin
    for (int n = 0; n < 2; n++) if (rsp_valid[n] === 1'b1) pop_check(n);
  end

  // Present a command, wait (bounded) for acceptance, push the expected response.
  // lat < 0 means no response is expected.
  task automatic issue(input int n, input logic [1:0] op, input logic [7:0] arg,
                       input logic [3:0] prio, input logic last,
                       input logic [7:0] exp_data, input logic exp_err, input int lat);
    exp_t e;
    int guard = 0;
    @(negedge CLK);
    cmd_valid[n] = 1'b1;
    cmd_op[n]    = op;
    cmd_arg[n]   = arg;
    cmd_prio[n]  = prio;
    cmd_last[n]  = last;
    while (cmd_ready[n] !== 1'b1 && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    if (cmd_ready[n] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL node%0d accept timeout: cmd_ready %b required 1", n, cmd_ready[n]);
      cmd_valid[n] = 1'b0;
      return;
    end
    @(posedge CLK);
    #1;
    cmd_valid[n] = 1'b0;
    if (lat >= 0) begin
      e.data = exp_data;
      e.err  = exp_err;
      e.cyc  = cyc + lat;
      if (n == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int n = 0; n < 2; n++) begin
      check($sformatf("%s node%0d op_word", tag, n), op_word[n], 16'h0000);
      check($sformatf("%s node%0d cmd_ready", tag, n), 16'(cmd_ready[n]), 16'h1);
      check($sformatf("%s node%0d busy", tag, n), 16'(busy[n]), 16'h0);
      check($sformatf("%s node%0d rsp_valid", tag, n), 16'(rsp_valid[n]), 16'h0);
      check($sformatf("%s node%0d rsp_data", tag, n), 16'(rsp_data[n]), 16'h0);
      check($sformatf("%s node%0d rsp_err", tag, n), 16'(rsp_err[n]), 16'h0);
    end
  endtask

  logic [15:0] seq1 [7];
  logic [15:0] seq2 [6];

  initial begin
    int guard;
    seq1 = '{16'hFC05, 16'hFC05, 16'hFC05, 16'h0C03, 16'hFC05, 16'hFCFF, 16'h0000};
    seq2 = '{16'hFC09, 16'hFC09, 16'hFC09, 16'hFC09, 16'hFCFF, 16'h0000};
    for (int n = 0; n < 2; n++) begin
      cmd_valid[n] = 1'b0;
      cmd_op[n]    = 2'b00;
      cmd_arg[n]   = 8'h00;
      cmd_prio[n]  = 4'h0;
      cmd_last[n]  = 1'b0;
    end

    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_outputs("reset");
    RST_N = 1'b1;
    @(negedge CLK);

    // Uncontended read of preset byte, releasing afterwards.
    issue(0, 2'b00, 8'h03, 4'h5, 1'b1, 8'h5A, 1'b0, 5);
    check("t1 busy after accept", 16'(busy[0]), 16'h1);
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      check($sformatf("t1 op_word[%0d]", i), op_word[0], seq1[i]);
    end

    // Write keeps the lock; the read is issued straight from LOCKED.
    issue(0, 2'b01, 8'hA7, 4'h5, 1'b0, 8'h00, 1'b0, 5);
    issue(0, 2'b00, 8'h00, 4'h5, 1'b1, 8'hA7, 1'b0, 2);
    @(negedge CLK);
    check("t2 op from locked", op_word[0], 16'h0C00);
    repeat (4) @(negedge CLK);

    // Priority 0 is promoted to 1.
    issue(0, 2'b00, 8'h03, 4'h0, 1'b1, 8'h5A, 1'b0, 5);
    @(negedge CLK);
    check("t3 prio0 start word", op_word[0], 16'hFC01);
    repeat (8) @(negedge CLK);

    // Contention: node1 (prio 9) beats node0 (prio 3); node0 follows after FCFF.
    fork
      issue(0, 2'b00, 8'h03, 4'h3, 1'b1, 8'h5A, 1'b0, 10);
      issue(1, 2'b00, 8'h00, 4'h9, 1'b1, 8'hA7, 1'b0, 5);
    join
    repeat (14) @(negedge CLK);

    // Timeout: node0 holds the lock, node1 gives up after 4 ARB cycles.
    issue(0, 2'b01, 8'h11, 4'h5, 1'b0, 8'h00, 1'b0, 5);
    repeat (6) @(negedge CLK);
    issue(1, 2'b00, 8'h00, 4'h9, 1'b1, 8'h00, 1'b1, 4);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check($sformatf("t5 node1 op_word[%0d]", i), op_word[1], seq2[i]);
    end
    check("t5 node1 busy after abort", 16'(busy[1]), 16'h0);
    issue(0, 2'b00, 8'h00, 4'h5, 1'b1, 8'h11, 1'b0, 2);
    repeat (6) @(negedge CLK);

    // Reset during HOLD: outputs drop at once and no response appears.
    issue(0, 2'b00, 8'h03, 4'h5, 1'b1, 8'h00, 1'b0, -1);
    repeat (4) @(posedge CLK);
    #2;
    check("t6 in hold", op_word[0], 16'hFC05);
    RST_N = 1'b0;
    #1;
    check_reset_outputs("t6 mid-hold reset");
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (8) @(negedge CLK);

    guard = 0;
    while ((exp_q0.size() > 0 || exp_q1.size() > 0) && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    if (exp_q0.size() > 0 || exp_q1.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL missing responses: node0 %0d node1 %0d outstanding, required 0",
               exp_q0.size(), exp_q1.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_mutex_client.md
# ram_mutex_client

Node-side initiator for the shared RAM mutex (function tag 4'hC). It accepts one command at a time from local node logic and arbitrates for the lock by driving the start word with a priority. Once granted, it issues the command word, captures the returned byte, and releases the lock with the stop word. One instance sits on each node; its `op_word` drives that node's `in_op_node<N>`, and its `grant_word` is fed from the mutex `out_node`.

## Interface
- `NODE_ID`, default 0: node index, 0 or 1. The expected grant byte is `8'h01 << NODE_ID`.
- `GRANT_TIMEOUT`, default 64: number of ARB cycles allowed without a grant before the request is aborted.
- `CLK` in, 1 bit: single clock, all state updates on the rising edge.
- `RST_N` in, 1 bit: reset is asynchronous and active-low.
- `cmd_valid` in, 1 bit: command request.
- `cmd_ready` out, 1 bit: command accepted when `cmd_valid && cmd_ready`.
- `cmd_op` in, 2 bits: 00 read, 01 write, 11 add frame, 10 garbage frame.
- `cmd_arg` in, 8 bits: read offset, or write data.
- `cmd_prio` in, 4 bits: arbitration priority; 0 is promoted to 1.
- `cmd_last` in, 1 bit: release the lock after this command.
- `rsp_valid` out, 1 bit: one-cycle pulse, one per accepted command.
- `rsp_data` out, 8 bits: returned byte; meaningful for reads, 0 otherwise.
- `rsp_err` out, 1 bit: qualifies `rsp_valid`; set on grant timeout or on lost grant.
- `busy` out, 1 bit: high whenever the state is not IDLE.
- `op_word` out, 16 bits: word driven to the mutex.
- `grant_word` in, 16 bits: mutex response word.

## Operation
- The FSM has six states: IDLE, ARB, OP, HOLD, LOCKED, STOP.
- IDLE
  - `op_word` = 16'h0000, `cmd_ready` = 1.
  - On accept: latch op, arg, last and priority; clear the timeout counter; go to ARB.
- ARB
  - `op_word` = 16'hFC00 | prio.
  - If `grant_word[15:8]` equals the grant byte, go to OP.
  - Otherwise increment the counter; when it reaches `GRANT_TIMEOUT`, flag the error and go to STOP.
- OP
  - Lasts exactly one cycle.
  - `op_word` = {2'b00, op, 4'hC, arg}.
  - Go to HOLD.
- HOLD
  - `op_word` = start word, which keeps the lock with no operation.
  - At the end of the cycle: capture `grant_word[7:0]` into `rsp_data`, pulse `rsp_valid`, and sample the grant byte.
  - Grant byte mismatch: set `rsp_err` and go to STOP.
  - Otherwise go to STOP if last is set, else to LOCKED.
- LOCKED
  - `op_word` = start word, `cmd_ready` = 1.
  - On accept: latch op, arg and last (priority is ignored); go to OP directly without re-arbitrating.
- STOP
  - `op_word` = 16'hFCFF for exactly one cycle, then go to IDLE.
  - On a timeout abort, STOP also pulses `rsp_valid` with `rsp_err`=1 and `rsp_data`=0.
- A timeout abort always sends STOP, never 16'h0000. The grant may land on the same edge, and 16'h0000 would leave the mutex locked forever.
- `cmd_ready` is combinational from state. It is 0 in ARB, OP, HOLD and STOP, so a `cmd_valid` held there is ignored.
- LOCKED may persist indefinitely. Starving the other node is the local logic's responsibility.

## Timing
- Reset values:
  - state = IDLE, `op_word` = 16'h0000.
  - `rsp_valid`, `rsp_err` and `busy` = 0; `rsp_data` = 8'h00.
  - `cmd_ready` = 1, counter = 0.
- Reset mid-operation: `op_word` returns to 0 immediately. Clearing the mutex lock is a system-reset requirement.
- Uncontended latency from an IDLE accept at edge E0:
  - Start word is driven after E0.
  - Grant is visible after E2 and sampled at E3.
  - OP is driven during E3–E4; the mutex registers the data at E4.
  - HOLD captures at E5; `rsp_valid` is high in the cycle after E5.
- Latency from LOCKED: accept at E0, OP during E0–E1, `rsp_valid` after E2.
- Back-to-back in LOCKED: one command per 3 cycles.
- Release: STOP is 1 cycle, then IDLE; earliest next IDLE accept is 2 cycles after the last `rsp_valid`.
- Timeout: exactly `GRANT_TIMEOUT` ARB cycles without a grant, then STOP.
- A grant and a timeout on the same edge: the grant wins.

## Structure
- Shared package `ram_mutex_pkg` holds:
  - START_BASE 16'hFC00, STOP_WORD 16'hFCFF, FUNC_TAG 4'hC.
  - The op enum (READ, WRITE, GARBAGE, ADD_FRAME).
  - A grant_byte(node) function.
- The mutex block and this client both import the package.
- No sub-module: the FSM, the timeout counter and the command latch are flat in one module.

## Test plan
- NODE_ID=0, uncontended read with arg 8'h03 and preset frame byte 8'h5A, cmd_last=1:
  - `op_word` sequence is FC0p, FC0p, FC0p, 0C03, FC0p, FCFF, 0000.
  - `rsp_valid` fires 5 edges after accept with `rsp_data`=8'h5A and `rsp_err`=0.
- Write 8'hA7 with last=0, then read offset 0 with last=1:
  - The second command is issued from LOCKED without a new start word.
  - The read returns 8'hA7.
- Both nodes request together, node0 prio 3 and node1 prio 9:
  - Node1 completes first.
  - Node0 waits in ARB, then completes after node1's FCFF.
- `GRANT_TIMEOUT`=4 with the other node holding the lock:
  - 4 ARB cycles, then a STOP cycle.
  - `rsp_valid` with `rsp_err`=1 and `rsp_data`=0; state returns to IDLE.
- cmd_prio=0: start word is 16'hFC01.
- Assert `RST_N` low during HOLD:
  - All outputs immediately take their reset values; no `rsp_valid` pulse.
